// File: rtl/sprite_pkg.sv
// Shared types for the sprite-sheet fetch path: picture IDs, tile descriptor,
// controller state encoding and the ID-to-rectangle lookup.
package sprite_pkg;

  localparam int unsigned PIC_WHITE     = 0;
  localparam int unsigned PIC_TETRIS1   = 1;
  localparam int unsigned PIC_TETRIS2   = 2;
  localparam int unsigned PIC_TETRIS3   = 3;
  localparam int unsigned PIC_TETRIS4   = 4;
  localparam int unsigned PIC_TETRIS5   = 5;
  localparam int unsigned PIC_TETRIS6   = 6;
  localparam int unsigned PIC_TETRIS7   = 7;
  localparam int unsigned PIC_GAMEOVER  = 9;
  localparam int unsigned PIC_INSTR     = 10;
  localparam int unsigned PIC_SPONGEBOB = 11;

  localparam int SPRITE_COORD_W = 10;
  localparam int TILE_SIZE      = 30;

  typedef struct packed {
    logic [SPRITE_COORD_W-1:0] base_x;
    logic [SPRITE_COORD_W-1:0] base_y;
    logic [SPRITE_COORD_W-1:0] w;
    logic [SPRITE_COORD_W-1:0] h;
  } sprite_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN
  } fetch_state_e;

  // Unknown IDs fall back to the white tile parked below the block column.
  function automatic sprite_desc_t sprite_lookup(input logic [31:0] id);
    sprite_desc_t d;
    d = '{base_x: 10'd0, base_y: 10'd320, w: 10'd30, h: 10'd30};
    if (id >= PIC_TETRIS1 && id <= PIC_TETRIS7) begin
      d.base_y = SPRITE_COORD_W'(TILE_SIZE * (id - 1));
    end else begin
      case (id)
        PIC_GAMEOVER:  d = '{base_x: 10'd290, base_y: 10'd0,   w: 10'd160, h: 10'd50};
        PIC_INSTR:     d = '{base_x: 10'd290, base_y: 10'd50,  w: 10'd160, h: 10'd140};
        PIC_SPONGEBOB: d = '{base_x: 10'd290, base_y: 10'd190, w: 10'd160, h: 10'd130};
        default:       d = d;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/sprite_fetch_ctrl_if.sv
// Request and address-stream bundle for sprite_fetch_ctrl.
// req_mirror exists only when SPRITE_FETCH_MIRROR_EN is defined.
interface sprite_fetch_ctrl_if #(
    parameter int ID_W    = 4,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 18
);
    logic               req_valid;
    logic [ID_W-1:0]    req_id;
    logic               req_ready;
    logic               abort;
`ifdef SPRITE_FETCH_MIRROR_EN
    logic               req_mirror;
`endif
    logic               addr_valid;
    logic               addr_ready;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               last;
    logic               busy;

    modport master (
`ifdef SPRITE_FETCH_MIRROR_EN
        output req_mirror,
`endif
        output req_valid, req_id, abort, addr_ready,
        input  req_ready, addr_valid, rom_addr, pix_x, pix_y, last, busy
    );

    modport slave (
`ifdef SPRITE_FETCH_MIRROR_EN
        input  req_mirror,
`endif
        input  req_valid, req_id, abort, addr_ready,
        output req_ready, addr_valid, rom_addr, pix_x, pix_y, last, busy
    );
endinterface

// File: rtl/sprite_rect_rom.sv
// Registered picture-ID to sheet-rectangle lookup; captures on the request
// handshake so the descriptor is ready during the controller's LOAD cycle.
module sprite_rect_rom
    import sprite_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_en,
    input  logic [ID_W-1:0] id,
    output sprite_desc_t desc
);
    sprite_desc_t desc_q, desc_d;

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        desc_d = desc_q;
        if (load_en) desc_d = sprite_lookup(32'(id));
    end

    // NOTE: a single registered word, not a memory array, so resetting it is cheap and safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) desc_q <= '0;
        else        desc_q <= desc_d;
    end

    assign desc = desc_q;
endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Sprite-sheet fetch controller: ID -> rectangle -> raster-order ROM addresses
// with valid/ready backpressure and abort. Optional mirror: SPRITE_FETCH_MIRROR_EN.
module sprite_fetch_ctrl
    import sprite_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int COORD_W = 10,
    parameter int SHEET_W = 480,
    parameter int ADDR_W  = 18
) (
    input logic               clk,
    input logic               rst_n,
    sprite_fetch_ctrl_if.slave bus
);
    fetch_state_e       state_q, state_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic [COORD_W-1:0] w_q, w_d, h_q, h_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               addr_valid_q, addr_valid_d;
    logic               last_q, last_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic [COORD_W-1:0] col;
    logic               accept;
    sprite_desc_t       desc;
`ifdef SPRITE_FETCH_MIRROR_EN
    logic               mirror_q, mirror_d;
`endif

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    sprite_rect_rom #(.ID_W(ID_W)) u_rect_rom (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (accept),
        .id      (bus.req_id),
        .desc    (desc)
    );

    always_comb begin
        state_d      = state_q;
        px_d         = px_q;
        py_d         = py_q;
        w_d          = w_q;
        h_d          = h_q;
        row_base_d   = row_base_q;
        addr_valid_d = addr_valid_q;
`ifdef SPRITE_FETCH_MIRROR_EN
        mirror_d     = mirror_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_LOAD;
`ifdef SPRITE_FETCH_MIRROR_EN
                    mirror_d = bus.req_mirror;
`endif
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    w_d          = COORD_W'(desc.w);
                    h_d          = COORD_W'(desc.h);
                    row_base_d   = ADDR_W'(desc.base_y) * ADDR_W'(SHEET_W) + ADDR_W'(desc.base_x);
                    px_d         = '0;
                    py_d         = '0;
                    addr_valid_d = 1'b1;
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bus.abort) begin
                    state_d      = ST_IDLE;
                    addr_valid_d = 1'b0;
                end else if (bus.addr_ready) begin
                    if (last_q) begin
                        state_d      = ST_IDLE;
                        addr_valid_d = 1'b0;
                    end else if (px_q == w_q - COORD_W'(1)) begin
                        // Row wrap steps the base by one pitch instead of multiplying.
                        px_d       = '0;
                        py_d       = py_q + COORD_W'(1);
                        row_base_d = row_base_q + ADDR_W'(SHEET_W);
                    end else begin
                        px_d = px_q + COORD_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        col = px_d;
`ifdef SPRITE_FETCH_MIRROR_EN
        if (mirror_d) col = w_d - COORD_W'(1) - px_d;
`endif
        // Outputs are computed from next-state values and registered, so a
        // stalled beat simply re-registers the same address.
        rom_addr_d  = row_base_d + ADDR_W'(col);
        last_d      = addr_valid_d && (px_d == w_d - COORD_W'(1)) && (py_d == h_d - COORD_W'(1));
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            px_q         <= '0;
            py_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            row_base_q   <= '0;
            rom_addr_q   <= '0;
            addr_valid_q <= 1'b0;
            last_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
`ifdef SPRITE_FETCH_MIRROR_EN
            mirror_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            px_q         <= px_d;
            py_q         <= py_d;
            w_q          <= w_d;
            h_q          <= h_d;
            row_base_q   <= row_base_d;
            rom_addr_q   <= rom_addr_d;
            addr_valid_q <= addr_valid_d;
            last_q       <= last_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
`ifdef SPRITE_FETCH_MIRROR_EN
            mirror_q     <= mirror_d;
`endif
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.pix_x      = px_q;
    assign bus.pix_y      = py_q;
    assign bus.last       = last_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Directed bench for sprite_fetch_ctrl: tile scans, backpressure, abort and reset.
module tb_sprite_fetch_ctrl;
    localparam int ID_W    = 4;
    localparam int COORD_W = 10;
    localparam int SHEET_W = 480;
    localparam int ADDR_W  = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sprite_fetch_ctrl_if #(.ID_W(ID_W), .COORD_W(COORD_W), .ADDR_W(ADDR_W)) bus ();

    sprite_fetch_ctrl #(
        .ID_W(ID_W), .COORD_W(COORD_W), .SHEET_W(SHEET_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int first_addr, last_addr, last_px, last_py;
    int addr_b1, addr_b29, addr_b30, ready_wait;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requests one tile and walks its address stream against a per-pixel model.
    task automatic run_tile(input int id, input bit mir, input int bx, input int by,
                            input int w, input int h, input bit stall, input int abort_at,
                            input string name);
        int beat, cycles, bad, x, y, col, exp_addr;
        int bad_beat, bad_addr, bad_x, bad_y, bad_eaddr, bad_ex, bad_ey;
        bit exp_last, rdy, aborted;
        logic bad_last, bad_valid;
        first_addr = -1; last_addr = -1; last_px = -1; last_py = -1;
        addr_b1 = -1; addr_b29 = -1; addr_b30 = -1;
        ready_wait = 0;
        bad = 0; bad_beat = 0; bad_addr = 0; bad_x = 0; bad_y = 0;
        bad_eaddr = 0; bad_ex = 0; bad_ey = 0; bad_last = 0; bad_valid = 0;
        aborted = 0;
        while (bus.req_ready !== 1'b1 && ready_wait < 20) begin
            step();
            ready_wait++;
        end
        n_assert++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_ready_wait: got %b want 1", name, bus.req_ready);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_id    = ID_W'(id);
`ifdef SPRITE_FETCH_MIRROR_EN
        bus.req_mirror = mir;
`endif
        step();
        bus.req_valid = 1'b0;
        n_assert++;
        if ({bus.addr_valid, bus.busy, bus.req_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s load_cycle: got valid/busy/ready=%b%b%b want 010",
                     name, bus.addr_valid, bus.busy, bus.req_ready);
        end
        step();
        n_assert++;
        if (bus.addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s first_beat_latency: got addr_valid=%b want 1", name, bus.addr_valid);
        end
        beat = 0;
        cycles = 0;
        while (beat < w * h && cycles < w * h * 4 + 20) begin
            x = beat % w;
            y = beat / w;
            col = mir ? (w - 1 - x) : x;
            exp_addr = (by + y) * SHEET_W + bx + col;
            exp_last = (beat == w * h - 1);
            if (bus.addr_valid !== 1'b1 || bus.rom_addr !== ADDR_W'(exp_addr) ||
                bus.pix_x !== COORD_W'(x) || bus.pix_y !== COORD_W'(y) || bus.last !== exp_last) begin
                if (bad == 0) begin
                    bad_beat = beat; bad_addr = int'(bus.rom_addr);
                    bad_x = int'(bus.pix_x); bad_y = int'(bus.pix_y);
                    bad_last = bus.last; bad_valid = bus.addr_valid;
                    bad_eaddr = exp_addr; bad_ex = x; bad_ey = y;
                end
                bad++;
            end
            if (beat == 0)  first_addr = int'(bus.rom_addr);
            if (beat == 1)  addr_b1    = int'(bus.rom_addr);
            if (beat == 29) addr_b29   = int'(bus.rom_addr);
            if (beat == 30) addr_b30   = int'(bus.rom_addr);
            if (bus.last === 1'b1) begin
                last_addr = int'(bus.rom_addr);
                last_px   = int'(bus.pix_x);
                last_py   = int'(bus.pix_y);
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (beat == abort_at) begin
                bus.abort = 1'b1;
                rdy = 1'b1;
            end
            bus.addr_ready = rdy;
            step();
            cycles++;
            bus.abort = 1'b0;
            if (beat == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (rdy) beat++;
        end
        bus.addr_ready = 1'b1;
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s addr_seq: %0d bad beats, first beat %0d got valid=%b addr=%0d x=%0d y=%0d last=%b want valid=1 addr=%0d x=%0d y=%0d",
                     name, bad, bad_beat, bad_valid, bad_addr, bad_x, bad_y, bad_last,
                     bad_eaddr, bad_ex, bad_ey);
        end
        n_assert++;
        if (aborted ? (beat != abort_at) : (beat != w * h)) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d want %0d", name, beat, aborted ? abort_at : w * h);
        end
        n_assert++;
        if ({bus.addr_valid, bus.req_ready, bus.busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s idle_after_end: got valid/ready/busy=%b%b%b want 010",
                     name, bus.addr_valid, bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #12;
        n_assert++;
        if ({bus.req_ready, bus.addr_valid, bus.last, bus.busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/valid/last/busy=%b%b%b%b want 1000",
                     bus.req_ready, bus.addr_valid, bus.last, bus.busy);
        end
        n_assert++;
        if (bus.rom_addr !== '0 || bus.pix_x !== '0 || bus.pix_y !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%0d x=%0d y=%0d want 0 0 0",
                     bus.rom_addr, bus.pix_x, bus.pix_y);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_tetris_block();
        run_tile(1, 1'b0, 0, 0, 30, 30, 1'b0, -1, "id1");
        n_assert++;
        if (first_addr != 0 || addr_b1 != 1 || addr_b30 != 480) begin
            n_fail++;
            $display("FAIL id1_corners: got first=%0d second=%0d row2=%0d want 0 1 480",
                     first_addr, addr_b1, addr_b30);
        end
        n_assert++;
        if (last_addr != 13949) begin
            n_fail++;
            $display("FAIL id1_last: got %0d want 13949", last_addr);
        end
    endtask

    task automatic test_gameover();
        run_tile(9, 1'b0, 290, 0, 160, 50, 1'b0, -1, "id9");
        n_assert++;
        if (first_addr != 290) begin
            n_fail++;
            $display("FAIL id9_first: got %0d want 290", first_addr);
        end
        n_assert++;
        if (last_addr != 23969 || last_px != 159 || last_py != 49) begin
            n_fail++;
            $display("FAIL id9_last: got addr=%0d x=%0d y=%0d want 23969 159 49",
                     last_addr, last_px, last_py);
        end
    endtask

    task automatic test_white();
        run_tile(0, 1'b0, 0, 320, 30, 30, 1'b0, -1, "id0");
        n_assert++;
        if (first_addr != 153600) begin
            n_fail++;
            $display("FAIL id0_first: got %0d want 153600", first_addr);
        end
        run_tile(15, 1'b0, 0, 320, 30, 30, 1'b0, -1, "id15");
        n_assert++;
        if (first_addr != 153600 || last_addr != 167549) begin
            n_fail++;
            $display("FAIL id15_span: got first=%0d last=%0d want 153600 167549", first_addr, last_addr);
        end
    endtask

    task automatic test_backpressure();
        run_tile(3, 1'b0, 0, 60, 30, 30, 1'b1, -1, "id3_stall");
        n_assert++;
        if (first_addr != 28800) begin
            n_fail++;
            $display("FAIL id3_first: got %0d want 28800", first_addr);
        end
    endtask

    task automatic test_abort();
        run_tile(11, 1'b0, 290, 190, 160, 130, 1'b0, 100, "id11_abort");
        run_tile(2, 1'b0, 0, 30, 30, 30, 1'b0, -1, "id2_after_abort");
        n_assert++;
        if (first_addr != 14400) begin
            n_fail++;
            $display("FAIL id2_first: got %0d want 14400", first_addr);
        end
        // Abort is ignored in IDLE (request still taken), then wins in LOAD.
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd6;
        bus.abort     = 1'b1;
        step();
        bus.req_valid = 1'b0;
        n_assert++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_idle: got busy=%b want 1", bus.busy);
        end
        step();
        bus.abort = 1'b0;
        n_assert++;
        if ({bus.addr_valid, bus.busy, bus.req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_in_load: got valid/busy/ready=%b%b%b want 001",
                     bus.addr_valid, bus.busy, bus.req_ready);
        end
        run_tile(5, 1'b0, 0, 120, 30, 30, 1'b0, 899, "id5_abort_last");
    endtask

    task automatic test_back_to_back();
        run_tile(7, 1'b0, 0, 180, 30, 30, 1'b0, -1, "id7");
        run_tile(4, 1'b0, 0, 90, 30, 30, 1'b0, -1, "id4_b2b");
        n_assert++;
        if (ready_wait != 0 || first_addr != 43200) begin
            n_fail++;
            $display("FAIL b2b_gap: got wait=%0d first=%0d want 0 43200", ready_wait, first_addr);
        end
    endtask

    task automatic test_reset_mid_scan();
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd10;
        step();
        bus.req_valid = 1'b0;
        step();
        for (int i = 0; i < 50; i++) step();
        n_assert++;
        if (bus.rom_addr !== ADDR_W'(24340) || bus.addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL id10_beat50: got addr=%0d valid=%b want 24340 1", bus.rom_addr, bus.addr_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if ({bus.req_ready, bus.addr_valid, bus.last, bus.busy} !== 4'b1000 ||
            bus.rom_addr !== '0 || bus.pix_x !== '0 || bus.pix_y !== '0) begin
            n_fail++;
            $display("FAIL mid_scan_reset: got ready/valid/last/busy=%b%b%b%b addr=%0d x=%0d y=%0d want 1000 0 0 0",
                     bus.req_ready, bus.addr_valid, bus.last, bus.busy, bus.rom_addr, bus.pix_x, bus.pix_y);
        end
        step();
        rst_n = 1'b1;
        step();
        run_tile(1, 1'b0, 0, 0, 30, 30, 1'b0, -1, "id1_after_reset");
    endtask

`ifdef SPRITE_FETCH_MIRROR_EN
    task automatic test_mirror();
        run_tile(1, 1'b1, 0, 0, 30, 30, 1'b0, -1, "id1_mirror");
        n_assert++;
        if (first_addr != 29 || addr_b29 != 0 || addr_b30 != 509) begin
            n_fail++;
            $display("FAIL mirror_corners: got first=%0d 30th=%0d row2=%0d want 29 0 509",
                     first_addr, addr_b29, addr_b30);
        end
        bus.req_mirror = 1'b0;
    endtask
`endif

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_id     = '0;
        bus.abort      = 1'b0;
        bus.addr_ready = 1'b1;
`ifdef SPRITE_FETCH_MIRROR_EN
        bus.req_mirror = 1'b0;
`endif
        test_reset();
        test_tetris_block();
        test_gameover();
        test_white();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef SPRITE_FETCH_MIRROR_EN
        test_mirror();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_fetch_ctrl.md
# sprite_fetch_ctrl

Parametrised sprite-sheet fetch controller for the Tetris VGA display path. It accepts a picture-ID request, resolves the ID to a sub-rectangle of the sprite-sheet ROM, then streams one ROM address per pixel in raster order. A valid/ready handshake connects it to the pixel pipeline. This is the sequential successor to the combinational picture-to-coordinate lookup: tile sizes are per-ID, the sheet geometry is parametrised, and there is backpressure and abort.

## Interface
- ID_W, 4, picture-ID width
- COORD_W, 10, sheet coordinate width
- SHEET_W, 480, sprite-sheet row pitch in pixels
- ADDR_W, 18, ROM address width; must satisfy SHEET_W*max(y+h) <= 2^ADDR_W
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_id  in  ID_W  picture ID
- req_ready  out  1  controller idle and able to accept
- abort  in  1  drop current scan
- addr_valid  out  1  rom_addr/pix_x/pix_y/last valid
- addr_ready  in  1  downstream accepts current address
- rom_addr  out  ADDR_W  sprite-sheet ROM address
- pix_x  out  COORD_W  x offset within tile
- pix_y  out  COORD_W  y offset within tile
- last  out  1  final pixel of tile
- busy  out  1  FSM not in IDLE

## Operation
- ID table (base_x, base_y, w, h):
  - IDs 1..7: (0, 30*(id-1), 30, 30), Tetris blocks.
  - ID 9: (290, 0, 160, 50), Game Over.
  - ID 10: (290, 50, 160, 140), Instruction.
  - ID 11: (290, 190, 160, 130), Sponge Bob.
  - Any other ID: (0, 320, 30, 30), white.
- FSM states are IDLE, LOAD and SCAN.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch the ID and go to LOAD.
- LOAD:
  - Register the table entry.
  - row_base = base_y*SHEET_W + base_x.
  - Clear px and py, then go to SCAN.
- SCAN:
  - addr_valid=1 and rom_addr = row_base + px.
  - When addr_valid & addr_ready, advance the pixel:
    - If px < w-1, then px++.
    - Otherwise px=0, py++ and row_base += SHEET_W. The row advance is incremental; there is no per-pixel multiply.
  - last=1 when px==w-1 and py==h-1.
  - An accepted last returns the FSM to IDLE.
- Backpressure: while addr_valid & !addr_ready, rom_addr, pix_x, pix_y and last hold stable.
- abort:
  - Has priority in LOAD and SCAN; the FSM goes to IDLE next cycle and addr_valid drops.
  - Ignored in IDLE.
  - If abort and an accepted last occur in the same cycle, the result is IDLE.
- req_valid is ignored outside IDLE; no queuing.
- All arithmetic is unsigned. row_base is ADDR_W bits. Overflow is a configuration error, not handled.

## Timing
- Reset values: state=IDLE, req_ready=1, addr_valid=0, rom_addr=0, pix_x=0, pix_y=0, last=0, busy=0.
- A request accepted at edge N gives first addr_valid=1 after edge N+2 (one LOAD cycle).
- With addr_ready held at 1: one address per cycle, w*h cycles of addr_valid, and req_ready=1 the cycle after the last handshake.
- Back-to-back: the next request can be accepted in the first IDLE cycle, so there are 2 dead cycles between tiles.
- Reset asserted mid-scan clears all state immediately (asynchronous). Outputs return to their reset values.
- All outputs are registered; there is no combinational path from addr_ready to rom_addr.

## Configuration
- SPRITE_FETCH_MIRROR_EN:
  - When defined, adds input req_mirror (1 bit), latched with req_id.
  - When mirrored, rom_addr = row_base + (w-1-px); pix_x still counts 0..w-1.
  - Undefined: no port and no mirror logic; addresses are always ascending.

## Structure
- Package sprite_pkg holds:
  - the picture-ID localparams (PIC_TETRIS1..7, PIC_GAMEOVER, PIC_INSTR, PIC_SPONGEBOB, PIC_WHITE);
  - the sprite_desc_t struct {base_x, base_y, w, h};
  - the lookup function sprite_lookup(id).
- One sub-module, sprite_rect_rom: registered ID-to-descriptor lookup, used in the LOAD cycle.

## Test plan
- Reset, then request ID 1 with addr_ready=1 -> 900 addresses, first 0, second 1, row 2 starts at 480, last at address 29*480+29=13949; req_ready returns the next cycle.
- Request ID 9 -> first rom_addr=290, w=160; last asserted at pix_x=159, pix_y=49, rom_addr=49*480+449=23969.
- Request ID 0 (and ID 15) -> white tile, first rom_addr=320*480=153600, 900 beats.
- ID 3 with addr_ready toggling pseudo-randomly -> address sequence identical to the stall-free run; outputs stable while stalled.
- Assert abort at beat 100 of ID 11 -> addr_valid=0 next cycle, req_ready=1; a new ID 2 request then starts at rom_addr=14400.
- With SPRITE_FETCH_MIRROR_EN, request ID 1 with req_mirror=1 -> first rom_addr=29, 30th=0, and row 2 starts at 509.
